// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential multiplier.
// FSM encoding, operation-mode constants and product width.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mul_if.sv
// Valid/ready handshake bundle for seq_mul.
// Operand side plus result side with backpressure.
interface mul_if
  import mul_pkg::*;
#(
  parameter int W = 4
) (
  input logic clk
);

  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         a;
  logic [W-1:0]         b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [prod_w(W)-1:0] c;

  modport dut (
    input  clk,
    input  rst,
    input  in_valid,
    input  a,
    input  b,
    input  signed_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output c
  );

  modport drv (
    input  clk,
    input  in_ready,
    input  out_valid,
    input  c,
    output rst,
    output in_valid,
    output a,
    output b,
    output signed_mode,
    output out_ready
  );

  modport mon (
    input clk,
    input rst,
    input in_valid,
    input in_ready,
    input a,
    input b,
    input signed_mode,
    input out_valid,
    input out_ready,
    input c
  );

endinterface

// File: rtl/seq_mul_cond_neg.sv
// Conditional two's-complement negate, any width.
// Used for operand magnitudes and result sign fix-up.
module cond_neg #(
  parameter int N = 4
) (
  input  logic         neg,
  input  logic [N-1:0] x,
  output logic [N-1:0] y
);

  // pass through or negate
  always_comb begin
    y = x;
    if (neg) begin
      y = ~x + N'(1);
    end
  end

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier, one bit per cycle.
// Signed ops run on magnitudes; sign applied on the last step.
module seq_mul
  import mul_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [prod_w(W)-1:0] c
);

  localparam int PW = prod_w(W);
  localparam int CW = $clog2(W);

  state_t state;
  state_t state_nx;

  logic [PW-1:0] mcand;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_sum;
  logic [PW-1:0] res;
  logic [W-1:0]  mplier;
  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;
  logic [CW-1:0] cnt;
  logic          neg;
  logic          sgn;
  logic          accept;
  logic          last;

  assign sgn    = (signed_mode == MODE_SIGNED);
  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(W - 1));

  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  cond_neg #(
    .N(W)
  ) u_neg_a (
    .neg(sgn && a[W-1]),
    .x  (a),
    .y  (mag_a)
  );

  cond_neg #(
    .N(W)
  ) u_neg_b (
    .neg(sgn && b[W-1]),
    .x  (b),
    .y  (mag_b)
  );

  cond_neg #(
    .N(PW)
  ) u_neg_c (
    .neg(neg),
    .x  (acc_sum),
    .y  (res)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (accept) state_nx = BUSY;
      end
      (state == BUSY): begin
        if (last) state_nx = DONE;
      end
      (state == DONE): begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // handshake output toward the producer
  always_comb begin
    in_ready = (state == IDLE) && !rst;
  end

  // datapath: load, shift-add, result and out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      c         <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (accept) begin
            mcand  <= {{W{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= sgn && (a[W-1] ^ b[W-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        (state == BUSY): begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            c         <= res;
            out_valid <= 1'b1;
          end
        end
        (state == DONE): begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul at W=4 and W=8.
// Drivers push expected products; monitors pop on handshake.
module tb_seq_mul;
  import mul_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  mul_if #(.W(4)) m4 (.clk(clk));
  mul_if #(.W(8)) m8 (.clk(clk));

  seq_mul #(.W(4)) dut4 (
    .clk        (clk),
    .rst        (m4.rst),
    .in_valid   (m4.in_valid),
    .in_ready   (m4.in_ready),
    .a          (m4.a),
    .b          (m4.b),
    .signed_mode(m4.signed_mode),
    .out_valid  (m4.out_valid),
    .out_ready  (m4.out_ready),
    .c          (m4.c)
  );

  seq_mul #(.W(8)) dut8 (
    .clk        (clk),
    .rst        (m8.rst),
    .in_valid   (m8.in_valid),
    .in_ready   (m8.in_ready),
    .a          (m8.a),
    .b          (m8.b),
    .signed_mode(m8.signed_mode),
    .out_valid  (m8.out_valid),
    .out_ready  (m8.out_ready),
    .c          (m8.c)
  );

  int errors = 0;
  int checks = 0;
  int got4 = 0;
  int got8 = 0;
  bit rnd_on = 1'b0;
  logic [7:0]  q4[$];
  logic [15:0] q8[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // W=4 result monitor
  always @(negedge clk) begin
    if (!m4.rst && m4.out_valid && m4.out_ready) begin
      got4++;
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon4_extra: got 0x%0h expected none", m4.c);
      end else begin
        check("mon4_c", 32'(m4.c), 32'(q4.pop_front()));
      end
    end
  end

  // W=8 result monitor
  always @(negedge clk) begin
    if (!m8.rst && m8.out_valid && m8.out_ready) begin
      got8++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon8_extra: got 0x%0h expected none", m8.c);
      end else begin
        check("mon8_c", 32'(m8.c), 32'(q8.pop_front()));
      end
    end
  end

  // random consumer backpressure on the W=8 side
  initial begin
    m8.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rnd_on) m8.out_ready = 1'($urandom_range(0, 1));
      else m8.out_ready = 1'b1;
    end
  end

  task automatic issue4(input logic [3:0] ta, input logic [3:0] tb_,
                        input logic sm, input logic [7:0] e,
                        input bit push, input bit lat);
    int k;
    int first;
    @(negedge clk);
    k = 0;
    while (!m4.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!m4.in_ready) begin
      check("in4_ready_timeout", 32'(m4.in_ready), 32'd1);
      return;
    end
    m4.a = ta;
    m4.b = tb_;
    m4.signed_mode = sm;
    m4.in_valid = 1'b1;
    if (push) q4.push_back(e);
    @(posedge clk);
    #1;
    m4.in_valid = 1'b0;
    m4.a = 4'($urandom);
    m4.b = 4'($urandom);
    m4.signed_mode = 1'($urandom);
    if (lat) begin
      first = 0;
      for (int i = 1; i <= 8 && first == 0; i++) begin
        @(posedge clk);
        #1;
        if (m4.out_valid) first = i;
      end
      check("latency4", 32'(first), 32'd4);
    end
  endtask

  task automatic drain4();
    int k;
    k = 0;
    while (q4.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("drain4", 32'(q4.size()), 32'd0);
  endtask

  task automatic issue8(input logic [7:0] ta, input logic [7:0] tb_,
                        input logic sm);
    logic [15:0] e;
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    int k;
    if (sm) begin
      sa = {{8{ta[7]}}, ta};
      sb = {{8{tb_[7]}}, tb_};
      e = 16'(sa * sb);
    end else begin
      e = {8'd0, ta} * {8'd0, tb_};
    end
    @(negedge clk);
    k = 0;
    while (!m8.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!m8.in_ready) begin
      check("in8_ready_timeout", 32'(m8.in_ready), 32'd1);
      return;
    end
    m8.a = ta;
    m8.b = tb_;
    m8.signed_mode = sm;
    m8.in_valid = 1'b1;
    q8.push_back(e);
    @(posedge clk);
    #1;
    m8.in_valid = 1'b0;
  endtask

  initial begin
    int k;
    int g;
    int seen;
    m4.rst = 1'b1;
    m8.rst = 1'b1;
    m4.in_valid = 1'b0;
    m8.in_valid = 1'b0;
    m4.a = '0;
    m4.b = '0;
    m8.a = '0;
    m8.b = '0;
    m4.signed_mode = MODE_UNSIGNED;
    m8.signed_mode = MODE_UNSIGNED;
    m4.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(m4.in_ready), 32'd0);
    check("rst_out_valid", 32'(m4.out_valid), 32'd0);
    check("rst_c", 32'(m4.c), 32'd0);
    m4.rst = 1'b0;
    m8.rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(m4.in_ready), 32'd1);

    issue4(4'd3, 4'd5, MODE_UNSIGNED, 8'h0F, 1, 1);
    issue4(4'd15, 4'd15, MODE_UNSIGNED, 8'hE1, 1, 0);
    issue4(4'hD, 4'h5, MODE_SIGNED, 8'hF1, 1, 0);
    issue4(4'hD, 4'h5, MODE_UNSIGNED, 8'h41, 1, 0);
    issue4(4'h8, 4'h8, MODE_SIGNED, 8'h40, 1, 0);
    issue4(4'h8, 4'h7, MODE_SIGNED, 8'hC8, 1, 0);
    issue4(4'h0, 4'h8, MODE_SIGNED, 8'h00, 1, 1);
    drain4();

    m4.out_ready = 1'b0;
    g = got4;
    issue4(4'd6, 4'd7, MODE_UNSIGNED, 8'h2A, 1, 0);
    k = 0;
    while (!m4.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp_out_valid_rise", 32'(m4.out_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(m4.out_valid), 32'd1);
      check("bp_c", 32'(m4.c), 32'h2A);
      check("bp_in_ready", 32'(m4.in_ready), 32'd0);
      m4.a = 4'd1;
      m4.b = 4'd1;
      m4.in_valid = (i % 2 == 0);
    end
    @(posedge clk);
    #1;
    m4.in_valid = 1'b0;
    m4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", 32'(m4.in_ready), 32'd1);
    check("rel_out_valid", 32'(m4.out_valid), 32'd0);
    check("rel_one_handshake", 32'(got4), 32'(g + 1));

    issue4(4'd5, 4'd5, MODE_UNSIGNED, 8'h00, 0, 0);
    @(posedge clk);
    #1;
    m4.rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", 32'(m4.out_valid), 32'd0);
    check("abort_c", 32'(m4.c), 32'd0);
    check("abort_in_ready_rst", 32'(m4.in_ready), 32'd0);
    m4.rst = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'(m4.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m4.out_valid) seen++;
    end
    check("abort_no_pulse", 32'(seen), 32'd0);
    issue4(4'd2, 4'd3, MODE_UNSIGNED, 8'h06, 1, 1);
    drain4();

    rnd_on = 1'b1;
    issue8(8'h80, 8'h80, MODE_SIGNED);
    issue8(8'hFF, 8'hFF, MODE_UNSIGNED);
    issue8(8'hFF, 8'hFF, MODE_SIGNED);
    issue8(8'h80, 8'h7F, MODE_SIGNED);
    for (int n = 0; n < 36; n++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    rnd_on = 1'b0;
    k = 0;
    while (q8.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drain8", 32'(q8.size()), 32'd0);
    repeat (12) @(negedge clk);
    check("count8", 32'(got8), 32'd40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_mul.md
# seq_mul

Parametrised sequential shift-add multiplier, the successor to the team's 4-bit combinational multiplier. It accepts one W×W operand pair through a valid/ready handshake and computes the product one bit per cycle. It supports unsigned and two's-complement signed operation, selected per operation. It returns the 2W-bit product through a second valid/ready handshake, and sits between operand-producing logic and result consumers that can apply backpressure.

## Interface
- W, default 4: operand width in bits; legal range 2–32. The product width is 2W.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  an operand pair is presented.
- in_ready  output  1  block can accept; equals (state==IDLE) && !rst.
- a  input  W  multiplicand.
- b  input  W  multiplier.
- signed_mode  input  1  selects the operation type; sampled with a and b at accept.
  - 1: a and b are two's complement.
  - 0: a and b are unsigned.
- out_valid  output  1  c holds a finished product; registered.
- out_ready  input  1  consumer takes the product.
- c  output  2W  product; registered.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - An accept occurs on an edge where in_valid && in_ready.
  - On accept, latch |a| into the multiplicand register, zero-extended to 2W bits.
  - On accept, latch |b| into the multiplier shift register.
  - On accept, latch neg = signed_mode && (a[W-1] ^ b[W-1]), clear the accumulator and bit counter, and go to BUSY.
  - Magnitudes are taken only when signed_mode=1. When signed_mode=0, operands are used as is.
- BUSY, each edge:
  - If the multiplier LSB is 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Increment the counter.
- After exactly W BUSY edges:
  - On the W-th edge, c is loaded with the accumulator result, two's-complement negated if neg=1.
  - On the same edge, out_valid is set and the state goes to DONE.
- DONE:
  - c and out_valid are held stable while out_ready=0.
  - On an edge with out_valid && out_ready, out_valid clears and the state goes to IDLE.
  - c keeps its last value after out_valid clears.
- in_valid is ignored in BUSY and DONE. Operand inputs are not required to be stable after accept.
- Arithmetic:
  - Unsigned: c = a*b, exact in 2W bits.
  - Signed: c = a*b in 2W-bit two's complement, exact for all inputs, including (−2^(W−1))·(−2^(W−1)) = 2^(2W−2).
  - |−2^(W−1)| = 2^(W−1) must be representable in the W-bit unsigned magnitude.
- Zero operand: no early termination; latency is always W.

## Timing
- Reset values on the edge where rst=1, from any state:
  - state=IDLE, out_valid=0, c=0, accumulator and counter=0.
  - in_ready=0 while rst=1, and 1 in the first cycle after rst falls.
- Reset mid-BUSY or mid-DONE aborts the operation. No out_valid pulse follows.
- Latency: an accept on edge E0 gives out_valid=1 immediately after edge E0+W.
- Release: a handshake on edge Ed returns the state to IDLE, so in_ready=1 after Ed. The next accept is no earlier than edge Ed+1.
- No same-cycle accept-while-done.
- Maximum throughput is one product per W+2 cycles when out_ready=1.
- in_ready and out_valid are never both 1.
- No combinational path from in_valid, a, b or out_ready to any output except the in_ready and rst term.

## Structure
- Shared package mul_pkg:
  - typedef enum for the FSM state (IDLE, BUSY, DONE).
  - localparam-style constants MODE_UNSIGNED=0 and MODE_SIGNED=1.
  - A function for the 2W product width.
- One natural sub-module: cond_neg, a parametrised-width combinational conditional two's-complement negate.
  - Instantiated twice for the W-bit operand magnitudes.
  - Instantiated once at 2W bits for result correction.
- FSM, counter, accumulator and shift registers stay in seq_mul.
- The existing mul_if interface is extended into a handshake interface carrying the ports above, for the bench.

## Test plan
- W=4, unsigned 3×5 → c=0x0F, out_valid rises exactly 4 cycles after accept; 15×15 → 0xE1.
- W=4, signed: −3×5 (a=0xD, b=0x5) → c=0xF1 (−15); the same bits unsigned → c=0x41 (65).
- W=4, signed corner cases:
  - −8×−8 → c=0x40.
  - −8×7 → c=0xC8.
  - 0×−8 → c=0x00, still 4 cycles.
- Backpressure:
  - Hold out_ready=0 for 6 cycles in DONE → c and out_valid stable, in_ready=0, in_valid pulses ignored.
  - Then out_ready=1 → one handshake, with in_ready=1 the next cycle.
- Assert rst=1 on the 2nd BUSY cycle → next cycle out_valid=0, c=0, IDLE. A fresh 2×3 after rst falls gives c=0x06.
- W=8, random signed/unsigned back-to-back stream with random out_ready → every c matches a reference model, with no lost or duplicated results.
